// File: rtl/serial_pkg.sv
// Shared constants for the serial two's-complement datapath and its capture stage.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/capture_bit_counter.sv
// Bit counter for the capture stage: clear, enable, terminal count at WIDTH-1.
module capture_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic Clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_capture.sv
// Sequences the upstream shift enable for WIDTH cycles and deserializes its LSB-first result.
// Optional parity output enabled by SERIAL_WORD_CAPTURE_PARITY_EN.
module serial_word_capture
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | shift_en high, sampling serial_in for WIDTH edges
  // HOLD  | captured word presented, waiting for out_ready

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, shifted;
  logic             cnt_clr, cnt_en, cnt_tc;

  assign shifted = {serial_in, sreg[WIDTH-1:1]};

  always_ff @(posedge Clock or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_tc)
          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ST_SHIFT;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore decode only, so start/out_ready never reach shift_en combinationally.
  assign shift_en  = (state == ST_SHIFT);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_HOLD);
  assign cnt_en    = shift_en && !cnt_tc;

  capture_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clock (Clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      data_out <= '0;
    end else if (shift_en) begin
      sreg <= shifted;
      if (cnt_tc)
        data_out <= shifted;
    end
  end

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  logic par_run;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      par_run    <= 1'b0;
      parity_out <= 1'b0;
    end else if (cnt_clr) begin
      par_run <= 1'b0;
    end else if (shift_en) begin
      par_run <= par_run ^ serial_in;
      if (cnt_tc)
        parity_out <= par_run ^ serial_in;
    end
  end
`endif

endmodule

// File: doc/serial_word_capture.md
Name: serial_word_capture

Overview:
- Downstream stage for the serial two's-complement unit.
- Sequences the unit's shift enable for exactly WIDTH cycles and deserializes its LSB-first serial result back into a parallel word.
- Presents the result on a valid/ready handshake to the consumer (register file or bus writer).

Parameters:
- WIDTH, 8: word length in bits; also the number of shift cycles per conversion.
- CNT_W, $clog2(WIDTH): bit-counter width; derived, not overridden.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a conversion; upstream word must already be loaded.
- serial_in  input  1  serial result bit from the upstream stage, LSB first; sampled on edges where shift_en=1.
- shift_en  output  1  drives the upstream shift_control; high for exactly WIDTH consecutive cycles per conversion.
- busy  output  1  high while in SHIFT or HOLD.
- data_out  output  WIDTH  captured word; stable while out_valid=1.
- out_valid  output  1  captured word available.
- out_ready  input  1  consumer accepts data_out when out_valid && out_ready at an edge.

Behaviour:
- Reset (asynchronous, any state, including mid-shift):
  - state=IDLE, shift reg=0, count=0.
  - shift_en=0, busy=0, out_valid=0, data_out=0.
  - A partial word is discarded.
- FSM states: IDLE, SHIFT, HOLD. shift_en, busy and out_valid are Moore outputs decoded from state only.
- IDLE:
  - start=1 -> SHIFT, count<=0.
  - start=0 -> stay.
- SHIFT:
  - shift_en=1.
  - Each edge: sreg <= {serial_in, sreg[WIDTH-1:1]}, count<=count+1.
  - On the edge where count==WIDTH-1: data_out <= {serial_in, sreg[WIDTH-1:1]}, state->HOLD.
  - start is ignored.
- HOLD:
  - out_valid=1; data_out held.
  - out_ready=1 and start=0 -> IDLE.
  - out_ready=1 and start=1 -> SHIFT with count<=0 (back-to-back conversion, no idle bubble).
  - out_ready=0 -> stay; start is ignored and not queued.
- Latency:
  - start sampled at edge E0.
  - shift_en high during cycles E0..E0+WIDTH-1 (WIDTH edges).
  - out_valid rises after edge E0+WIDTH.
  - Throughput with out_ready held high: one word per WIDTH+1 cycles.
- Counter:
  - Range 0..WIDTH-1; never wraps within a conversion.
  - Reset to 0 on entry to SHIFT.
- Bit order: the first captured bit lands in data_out[0], the last in data_out[WIDTH-1].
- Glitch-free requirement: no combinational path from start or out_ready to shift_en.

Optional Feature:
- Macro: SERIAL_WORD_CAPTURE_PARITY_EN.
- Defined:
  - Adds output parity_out (1 bit).
  - Running XOR of sampled serial_in bits, cleared on entry to SHIFT.
  - Registered alongside data_out; equals ^data_out while out_valid=1.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_HOLD=2'd2.
  - Default WIDTH constant shared with the two's-complement unit.
- Sub-module capture_bit_counter:
  - Parameterised CNT_W counter with clear, enable and terminal-count output (count==WIDTH-1).
- The FSM and shift register stay in the top module.

Test Plan:
- Basic capture: upstream loaded with 8'h14, pulse start.
  - shift_en high exactly 8 cycles.
  - serial_in sequence 0,0,1,1,0,1,1,1.
  - out_valid rises 9 edges after start; data_out=8'hEC.
- Back-to-back: out_ready tied 1; start asserted in the HOLD cycle with next word 8'h01.
  - Second shift_en burst begins the very next cycle.
  - data_out=8'hFF.
  - No IDLE cycle between bursts.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - data_out=8'hEC held and out_valid stays 1.
  - start pulses during HOLD are ignored (no shift_en).
  - Accept on the cycle out_ready=1 -> IDLE.
- Reset mid-operation: assert reset after 3 shift cycles.
  - All outputs 0 immediately (async), state IDLE.
  - A fresh start then captures 8'h80 correctly from upstream 8'h80.
- Start ignored while shifting: extra start pulses at shift cycles 2 and 5.
  - Burst length remains 8.
  - Single out_valid; data_out unaffected.
- Parity (macro defined):
  - Word 8'hEC -> parity_out=1.
  - Word 8'hFF -> parity_out=0.
  - Undefined build exposes no parity_out port.
